// File: rtl/shift_register_right_sequencer.sv
// shift_register_right_sequencer
//   Right-shifting operand register with its own shift sequencer. A word is
//   loaded on an accepted start. It is then shifted out LSB first, one bit per
//   enabled cycle, until the latched target count is reached. A one-cycle
//   ready pulse follows the last shift.
//
//   state | meaning
//   IDLE  | waiting for start; register and bitIndex hold the last result
//   SHIFT | shifting on every cycle with shiftEnable high
//   DONE  | one-cycle ready pulse, then back to IDLE
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous clear, active high
//   sys_reset      synchronous clear, active high, overrides everything
//   start          load request, only honoured in IDLE
//   parallelInput  word loaded on an accepted start
//   shiftCount     shifts to perform (0 or above WORD_LENGTH -> WORD_LENGTH)
//   arith          1 = replicate MSB, 0 = fill MSB from serialInput (latched)
//   serialInput    MSB fill bit for logical shifts
//   shiftEnable    advance qualifier in SHIFT
//   serialOutput   register bit 0
//   parallelOutput register contents
//   bitIndex       shifts completed since the last load
//   busy           high in SHIFT
//   ready          high in DONE
module shift_register_right_sequencer #(
  parameter int WORD_LENGTH = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sys_reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] parallelInput,
  input  logic [COUNT_WIDTH-1:0] shiftCount,
  input  logic                   arith,
  input  logic                   serialInput,
  input  logic                   shiftEnable,
  output logic                   serialOutput,
  output logic [WORD_LENGTH-1:0] parallelOutput,
  output logic [COUNT_WIDTH-1:0] bitIndex,
  output logic                   busy,
  output logic                   ready
);

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(WORD_LENGTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [WORD_LENGTH-1:0] shift_reg;
  logic [COUNT_WIDTH-1:0] bit_count;
  logic [COUNT_WIDTH-1:0] target;
  logic                   arith_q;

  logic [COUNT_WIDTH-1:0] count_inc;
  logic [COUNT_WIDTH-1:0] load_target;
  logic                   fill_bit;
  logic                   last_shift;

  assign count_inc   = bit_count + COUNT_WIDTH'(1);
  assign last_shift  = shiftEnable && (count_inc == target);
  assign fill_bit    = arith_q ? shift_reg[WORD_LENGTH-1] : serialInput;
  // Zero means a full-word shift; oversize requests are clamped so bitIndex
  // can never exceed WORD_LENGTH.
  assign load_target = ((shiftCount == '0) || (shiftCount > FULL_COUNT)) ?
                       FULL_COUNT : shiftCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (sys_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_count <= '0;
      target    <= '0;
      arith_q   <= 1'b0;
    end else if (sys_reset) begin
      shift_reg <= '0;
      bit_count <= '0;
      target    <= '0;
      arith_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= parallelInput;
            bit_count <= '0;
            target    <= load_target;
            arith_q   <= arith;
          end
        end
        SHIFT: begin
          if (shiftEnable) begin
            shift_reg <= {fill_bit, shift_reg[WORD_LENGTH-1:1]};
            bit_count <= count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign serialOutput   = shift_reg[0];
  assign parallelOutput = shift_reg;
  assign bitIndex       = bit_count;
  assign busy           = (state == SHIFT);
  assign ready          = (state == DONE);

endmodule

// File: doc/shift_register_right_sequencer.md
Name: shift_register_right_sequencer

Overview:
- Right-shifting operand register with a built-in shift sequencer for the sequential multiplier, divider and square-root datapaths.
- Loads a word and then shifts it out serially, LSB first, one bit per enabled cycle.
- Stops by itself after a programmed number of shifts, then raises a one-cycle ready pulse for the datapath controller.
- Complements the MSB-first left shift register: it supplies the multiplier/quotient bit stream from the low end.

Parameters:
- WORD_LENGTH, 8: register width in bits (minimum 2).
- COUNT_WIDTH, 4: width of the shift counter and of shiftCount; must satisfy 2^COUNT_WIDTH > WORD_LENGTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sys_reset  input  1  synchronous clear, active-high.
- start  input  1  load request, sampled only in IDLE.
- parallelInput  input  WORD_LENGTH  word loaded on an accepted start.
- shiftCount  input  COUNT_WIDTH  number of shifts to perform; 0 means WORD_LENGTH.
- arith  input  1  fill mode: 1 = arithmetic (replicate MSB), 0 = fill from serialInput; latched on start.
- serialInput  input  1  MSB fill bit when arith=0.
- shiftEnable  input  1  advance qualifier in SHIFT; when low, the block stalls.
- serialOutput  output  1  current register bit 0.
- parallelOutput  output  WORD_LENGTH  current register contents.
- bitIndex  output  COUNT_WIDTH  shifts completed since the last load.
- busy  output  1  high in SHIFT.
- ready  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (reset=1, asynchronous): register=0, bitIndex=0, state=IDLE, busy=0, ready=0, latched arith=0, latched target=0. Therefore serialOutput=0 and parallelOutput=0.
- sys_reset=1 on a clock edge: same clear as reset, synchronously. It has priority over every other input, including start.
- States:
  - IDLE -> SHIFT when start=1. On that edge: register<=parallelInput, bitIndex<=0, arith latched, target latched (shiftCount==0 ? WORD_LENGTH : shiftCount).
  - SHIFT, shiftEnable=1: register<={fill, register[WORD_LENGTH-1:1]}, bitIndex<=bitIndex+1. fill = register[MSB] when latched arith=1, else serialInput.
  - SHIFT, shiftEnable=0: hold everything.
  - SHIFT -> DONE on the enabled shift where bitIndex+1 == target. That shift is still performed.
  - DONE -> IDLE unconditionally after one cycle. ready=1 only while in DONE.
- Outputs are registered/state-decoded: busy=(state==SHIFT), ready=(state==DONE).
- Latency: a load on edge 0 with shifts enabled every cycle gives ready high during cycle target+1 after the load edge, and IDLE one cycle later.
- start while in SHIFT or DONE is ignored; no re-load and no error. start in IDLE during the cycle after DONE is accepted normally.
- shiftCount and arith changing after the load have no effect until the next load.
- Targets above WORD_LENGTH are clamped to WORD_LENGTH.
- Register, parallelOutput and bitIndex hold their values in DONE and IDLE until the next load or clear.
- bitIndex never wraps; maximum value is WORD_LENGTH.
- Reset asserted mid-operation aborts immediately to the reset state. ready is not emitted for an aborted run.

Test Plan:
- Reset mid-SHIFT (bitIndex=3) -> outputs immediately 0, busy=0, state IDLE, no ready pulse afterwards.
- Logical run: WORD_LENGTH=8, load 0xB5, shiftCount=0, arith=0, serialInput=0, shiftEnable=1 -> serialOutput sequence 1,0,1,0,1,1,0,1. ready pulses exactly once, 9 cycles after the load edge. Final parallelOutput=0x00, bitIndex=8.
- Arithmetic partial run: load 0x90, shiftCount=3, arith=1 -> parallelOutput 0xC8, 0xE4, 0xF2. Then ready, and the value holds at 0xF2 in IDLE.
- Stall: load 0x0F, shiftCount=4, shiftEnable toggling 1,0,0,1,1,0,1 -> bitIndex advances only on enabled cycles. ready follows the 4th enabled shift; result 0x00.
- Ignored start and sys_reset priority: start with 0xFF during SHIFT -> no reload. Then sys_reset and start asserted together in IDLE -> register=0, state IDLE.
- Clamp and back-to-back: shiftCount=12 with WORD_LENGTH=8 -> 8 shifts. start asserted in the cycle after DONE -> new load accepted, busy high on the next cycle.
